serial_compare_ctrl: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands using one shared instance of the team's 2-bit `Comparator` cell. It steps the cell MSB-digit first, one 2-bit digit per clock, and stops at the first unequal digit. It sits between a requester that issues `start` with operands and any logic that needs a registered GT/LT/EQ verdict without a full-width combinational comparator. Results are held until the next accepted request.

---
 rtl/serial_compare_ctrl_if.sv | 29 ++
 rtl/serial_compare_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_compare_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// Request/verdict bundle between a requester and serial_compare_ctrl.
// The requester drives start/A/B; the controller returns busy/done and the verdict flags.
interface serial_compare_ctrl_if #(
   parameter int WIDTH = 8
);
   // start is a level sampled on every rising edge; it is accepted only while the
   // controller is idle (busy=0, done=0) and is otherwise dropped, never queued.
   // A/B are sampled only on the accepting edge. done pulses for one cycle and
   // GT/LT/EQ stay valid from that cycle until the next accepted start.
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             GT;
   logic             LT;
   logic             EQ;
   logic [1:0]       state_dbg;

   modport master (
      output start, A, B,
      input  busy, done, GT, LT, EQ, state_dbg
   );

   modport slave (
      input  start, A, B,
      output busy, done, GT, LT, EQ, state_dbg
   );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB digit first through
// one shared 2-bit Comparator cell, stopping at the first unequal digit.
module Comparator (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       gt,
   output logic       lt,
   output logic       eq
);
   logic hi_eq;

   assign hi_eq = ~(a[1] ^ b[1]);
   assign gt    = (a[1] & ~b[1]) | (hi_eq & a[0] & ~b[0]);
   assign lt    = (~a[1] & b[1]) | (hi_eq & ~a[0] & b[0]);
   assign eq    = hi_eq & ~(a[0] ^ b[0]);
endmodule

module serial_compare_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_compare_ctrl_if.slave  bus
);
   localparam int DIGITS = WIDTH / 2;
   localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDXW-1:0] IDX_MSB = IDXW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [IDXW-1:0]   idx;
   logic              busy_q;
   logic              done_q;
   logic              gt_q;
   logic              lt_q;
   logic              eq_q;

   logic [1:0]        a_dig;
   logic [1:0]        b_dig;
   logic              cell_gt;
   logic              cell_lt;
   logic              cell_eq;

   // Digit select is an equality-decoded mux so the cell stays the only magnitude logic.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (idx == IDXW'(d)) begin
            a_dig = a_q[2*d +: 2];
            b_dig = b_q[2*d +: 2];
         end
      end
   end

   Comparator u_cell (
      .a  (a_dig),
      .b  (b_dig),
      .gt (cell_gt),
      .lt (cell_lt),
      .eq (cell_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         gt_q   <= 1'b0;
         lt_q   <= 1'b0;
         eq_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q    <= bus.A;
                  b_q    <= bus.B;
                  idx    <= IDX_MSB;
                  gt_q   <= 1'b0;
                  lt_q   <= 1'b0;
                  eq_q   <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (cell_gt || cell_lt) begin
                  gt_q   <= cell_gt;
                  lt_q   <= cell_lt;
                  eq_q   <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else if (idx == '0) begin
                  // Every digit matched: operands are equal.
                  gt_q   <= 1'b0;
                  lt_q   <= 1'b0;
                  eq_q   <= cell_eq;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.GT        = gt_q;
   assign bus.LT        = lt_q;
   assign bus.EQ        = eq_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed and randomized checks of serial_compare_ctrl against an arithmetic reference
// (A>B / A<B / A==B and the position of the highest differing bit).
module tb_serial_compare_ctrl;
   localparam int W      = 8;
   localparam int DIGITS = W / 2;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   serial_compare_ctrl_if #(.WIDTH(W)) bus ();

   serial_compare_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: verdict from plain arithmetic; digits examined from the top set bit of A^B.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int m, output logic [2:0] flags);
      logic [W-1:0] x;
      x = a ^ b;
      m = DIGITS;
      for (int i = 0; i < W; i++) if (x[i]) m = DIGITS - i / 2;
      flags = {a > b, a < b, a == b};
   endtask

   function automatic logic [2:0] flags_now();
      return {bus.GT, bus.LT, bus.EQ};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts from idle; checks busy/flags through RUN, the done cycle and the return to idle.
   task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit noisy, input string tag);
      int         m;
      logic [2:0] ef;
      model(a, b, m, ef);
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      tick();
      for (int k = 1; k <= m; k++) begin
         chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
         chk({tag, ".run_done"}, 32'(bus.done), 32'd0);
         chk({tag, ".run_flags"}, 32'(flags_now()), 32'd0);
         bus.start = noisy && (k == 2);
         bus.A     = noisy ? 8'hFF : W'($urandom);
         bus.B     = noisy ? 8'h00 : W'($urandom);
         tick();
      end
      bus.start = 1'b0;
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".end_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".flags"}, 32'(flags_now()), 32'(ef));
      tick();
      chk({tag, ".done_fall"}, 32'(bus.done), 32'd0);
      chk({tag, ".flags_hold"}, 32'(flags_now()), 32'(ef));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.A        = '0;
      bus.B        = '0;

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.flags", 32'(flags_now()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases, including best and worst latency.
      do_compare(8'h00, 8'h00, 1'b0, "eq_zero");
      do_compare(8'hA5, 8'h5A, 1'b0, "early_gt");
      do_compare(8'h12, 8'h13, 1'b0, "late_lt");
      do_compare(8'hFF, 8'hFF, 1'b0, "eq_ones");
      do_compare(8'hC0, 8'h80, 1'b0, "msb_gt");
      do_compare(8'h01, 8'h02, 1'b1, "ignored_start");

      // start held high: ignored in DONE, accepted on the following edge with new operands.
      bus.A     = 8'h12;
      bus.B     = 8'h13;
      bus.start = 1'b1;
      tick();
      bus.A = 8'h80;
      bus.B = 8'h40;
      repeat (4) tick();
      chk("hold.done", 32'(bus.done), 32'd1);
      chk("hold.flags", 32'(flags_now()), 32'b010);
      tick();
      chk("hold.ignored_busy", 32'(bus.busy), 32'd0);
      chk("hold.ignored_done", 32'(bus.done), 32'd0);
      chk("hold.ignored_flags", 32'(flags_now()), 32'b010);
      tick();
      chk("hold.accept_busy", 32'(bus.busy), 32'd1);
      chk("hold.accept_flags", 32'(flags_now()), 32'd0);
      bus.start = 1'b0;
      tick();
      chk("hold.second_done", 32'(bus.done), 32'd1);
      chk("hold.second_flags", 32'(flags_now()), 32'b100);
      tick();

      // Reset in the middle of RUN: outputs clear at once and no done follows.
      bus.A     = 8'h00;
      bus.B     = 8'h00;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", 32'(bus.busy), 32'd0);
      chk("midrst.done", 32'(bus.done), 32'd0);
      chk("midrst.flags", 32'(flags_now()), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("midrst.quiet_done", 32'(bus.done), 32'd0);
         chk("midrst.quiet_busy", 32'(bus.busy), 32'd0);
      end
      do_compare(8'h3C, 8'h3D, 1'b0, "after_rst");

      // Verdict holds while operands wander with no start.
      do_compare(8'hC0, 8'h80, 1'b0, "iso_gt");
      for (int k = 0; k < 10; k++) begin
         bus.A = W'($urandom);
         bus.B = W'($urandom);
         tick();
         chk("iso.gt_hold", 32'(flags_now()), 32'b100);
         chk("iso.done_low", 32'(bus.done), 32'd0);
      end

      // Randomized operands, biased toward equal and near-equal pairs.
      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ W'(1 << $urandom_range(0, W - 1));
            default: b = W'($urandom);
         endcase
         do_compare(a, b, 1'b0, "rand");
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
